// File: rtl/audio_i2s_slave.sv
// I2S slave: receives L/R words from an external bit-clock master and returns
// transmit words on oAUD_ADCDAT, all in the iCLK domain.
module audio_i2s_slave #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iAUD_BCK,
  input  logic                         iAUD_LRCK,
  input  logic                         iAUD_DATA,
  output logic                         oAUD_ADCDAT,
  input  logic signed [DATA_WIDTH-1:0] iAUD_extL,
  input  logic signed [DATA_WIDTH-1:0] iAUD_extR,
  output logic signed [DATA_WIDTH-1:0] oAUD_outL,
  output logic signed [DATA_WIDTH-1:0] oAUD_outR,
  output logic                         oVALID,
  output logic                         oFRAME_ERR
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {HUNT, RX} state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_bck_sync, r_lrck_sync, r_data_sync;
  logic                    r_bck_prev;
  logic                    r_lrck_last;
  logic                    r_lrck_seen;
  logic [CW-1:0]           r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_rx_shift, r_holdL, r_txR, r_tx_shift;
  logic                    r_word_done, r_word_left, r_left_ok;

  logic                    w_bck, w_lrck, w_data, w_rise, w_boundary;
  logic [DATA_WIDTH-1:0]   w_tx_load;

  assign w_bck      = r_bck_sync[SYNC_STAGES-1];
  assign w_lrck     = r_lrck_sync[SYNC_STAGES-1];
  assign w_data     = r_data_sync[SYNC_STAGES-1];
  assign w_rise     = w_bck & ~r_bck_prev;
  // The first rise after reset only records LRCK, so a mid-word release
  // cannot masquerade as a word boundary.
  assign w_boundary = w_rise & r_lrck_seen & (w_lrck != r_lrck_last);
  assign w_tx_load  = w_lrck ? iAUD_extL : r_txR;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_bck_sync  <= '0;
      r_lrck_sync <= '0;
      r_data_sync <= '0;
      r_bck_prev  <= 1'b0;
    end else begin
      r_bck_sync[0]  <= iAUD_BCK;
      r_lrck_sync[0] <= iAUD_LRCK;
      r_data_sync[0] <= iAUD_DATA;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_bck_sync[i]  <= r_bck_sync[i-1];
        r_lrck_sync[i] <= r_lrck_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_bck_prev <= w_bck;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= HUNT;
      r_lrck_last <= 1'b0;
      r_lrck_seen <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_holdL     <= '0;
      r_txR       <= '0;
      r_tx_shift  <= '0;
      r_word_done <= 1'b0;
      r_word_left <= 1'b0;
      r_left_ok   <= 1'b0;
      oAUD_outL   <= '0;
      oAUD_outR   <= '0;
      oVALID      <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      oAUD_ADCDAT <= 1'b0;
    end else begin
      oVALID      <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      r_word_done <= 1'b0;
      if (w_rise) begin
        r_lrck_seen <= 1'b1;
        r_lrck_last <= w_lrck;
        if (w_boundary) begin
          if (r_state == RX && r_bit_cnt != CW'(DATA_WIDTH)) begin
            oFRAME_ERR <= 1'b1;
            r_left_ok  <= 1'b0;
          end
          r_state     <= RX;
          r_bit_cnt   <= CW'(1);
          r_rx_shift  <= {{(DATA_WIDTH-1){1'b0}}, w_data};
          r_word_left <= w_lrck;
          if (w_lrck) begin
            r_txR <= iAUD_extR;
          end
          oAUD_ADCDAT <= w_tx_load[DATA_WIDTH-1];
          r_tx_shift  <= {w_tx_load[DATA_WIDTH-2:0], 1'b0};
        end else if (r_state == RX) begin
          if (r_bit_cnt != CW'(DATA_WIDTH)) begin
            r_bit_cnt   <= r_bit_cnt + 1'b1;
            r_rx_shift  <= {r_rx_shift[DATA_WIDTH-2:0], w_data};
            r_word_done <= (r_bit_cnt == CW'(DATA_WIDTH - 1));
          end
          // Zeros fill in behind the word, so bits past DATA_WIDTH read 0.
          oAUD_ADCDAT <= r_tx_shift[DATA_WIDTH-1];
          r_tx_shift  <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
          oAUD_ADCDAT <= 1'b0;
        end
      end
      if (r_word_done) begin
        if (r_word_left) begin
          r_holdL   <= r_rx_shift;
          r_left_ok <= 1'b1;
        end else if (r_left_ok) begin
          oAUD_outL <= r_holdL;
          oAUD_outR <= r_rx_shift;
          oVALID    <= 1'b1;
          r_left_ok <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/audio_i2s_slave.md
AUDIO_I2S_SLAVE -- requirements
Module: audio_i2s_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16; bits per channel word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; synchronizer depth for the serial inputs.
REQ-003 SHALL have port iCLK, input, 1; the only clock. One clock; reset is asynchronous and active-high.
REQ-004 SHALL have port iRST, input, 1; asynchronous, active-high reset.
REQ-005 SHALL have port iAUD_BCK, input, 1; bit clock from the external master.
REQ-006 SHALL have port iAUD_LRCK, input, 1; word select; 1 = left, 0 = right.
REQ-007 SHALL have port iAUD_DATA, input, 1; serial data from the master, MSB first.
REQ-008 SHALL have port oAUD_ADCDAT, output, 1; serial data returned to the master, MSB first.
REQ-009 SHALL have ports iAUD_extL and iAUD_extR, input, DATA_WIDTH, signed; words to transmit.
REQ-010 SHALL have ports oAUD_outL and oAUD_outR, output, DATA_WIDTH, signed; received words.
REQ-011 SHALL have port oVALID, output, 1; one-cycle pulse when a new L/R pair is on oAUD_outL/R.
REQ-012 SHALL have port oFRAME_ERR, output, 1; one-cycle pulse when a short word is discarded.

Function
REQ-013 SHALL pass iAUD_BCK, iAUD_LRCK and iAUD_DATA through SYNC_STAGES flops, then one edge-detect flop on BCK.
- Rise event: synced BCK = 1 and previous = 0.
- Fall event: synced BCK = 0 and previous = 1.
REQ-014 SHALL work correctly when each BCK high and low phase lasts at least SYNC_STAGES+1 iCLK cycles. Example: 18.432 MHz iCLK with 1.536 MHz BCK gives 6-cycle phases.
REQ-015 SHALL sample synced LRCK and DATA only on rise events; the master changes data on BCK falling edges.
REQ-016 SHALL detect a word boundary on the rise event where sampled LRCK differs from the LRCK sampled at the previous rise event. The bit sampled on that rise is the MSB of the new word; there is no one-bit delay.
REQ-017 SHALL implement state machine HUNT -> RX.
- HUNT: discard all bits; move to RX on the first word boundary; that boundary's bit is the new word's MSB.
- RX: shift bits in; on each word boundary, close the previous word and start the new one.
REQ-018 SHALL keep a bit counter that starts at 1 on a boundary and increments per rise event. It SHALL saturate at DATA_WIDTH; bits beyond DATA_WIDTH are ignored.
REQ-019 SHALL close the word when the counter reaches DATA_WIDTH and latch it into a holding register for the channel indicated by LRCK.
- The latch occurs in the cycle after the rise event that delivered bit DATA_WIDTH.
REQ-020 SHALL update oAUD_outL and oAUD_outR together, and pulse oVALID for one cycle, when a right word completes and a left word completed earlier in the same frame. A lone right word SHALL NOT produce oVALID.
REQ-021 SHALL handle a boundary that arrives with counter < DATA_WIDTH as follows:
- discard the partial word;
- pulse oFRAME_ERR one cycle later;
- clear the left-complete flag;
- start the new word normally.
REQ-022 SHALL capture iAUD_extL and iAUD_extR into transmit registers on the rise event that is a 0->1 LRCK boundary (left start).
REQ-023 SHALL drive oAUD_ADCDAT from registered logic updated on rise events, so it is stable at the master's falling-edge sample.
- The boundary rise drives the MSB; each following rise drives the next lower bit.
- After DATA_WIDTH bits, oAUD_ADCDAT is driven 0.
- The left word comes from the captured value; the right word comes from the value captured at the preceding left start.
REQ-024 SHALL drive oAUD_ADCDAT 0 while in HUNT.
REQ-025 SHALL ignore fall events except for edge tracking.

Reset
REQ-026 SHALL, while iRST = 1, asynchronously clear:
- oAUD_outL, oAUD_outR, oVALID, oFRAME_ERR, oAUD_ADCDAT: 0;
- synchronizer and edge flops, shift registers, transmit registers, counter, flags: 0;
- state: HUNT.
REQ-027 SHALL, after reset deasserts mid-frame, emit no oVALID until a complete left word followed by a complete right word has been received after the first boundary.
REQ-028 SHALL, if reset asserts mid-word, discard the partial word with no oVALID and no oFRAME_ERR.

Verification
REQ-029 Nominal: master sends L = 16'h8001, R = 16'h7FFE at 48 kHz with 1.536 MHz BCK -> from the second frame on, oAUD_outL = 8001 and oAUD_outR = 7FFE, with exactly one oVALID per frame.
REQ-030 Loopback: iAUD_extL = 16'hA5C3, iAUD_extR = 16'h3C5A; decode oAUD_ADCDAT on BCK falling edges -> master recovers A5C3 and 3C5A.
REQ-031 Long words: 24 BCK per channel carrying 16'h1234 followed by 8 extra 1s -> output 1234, no oFRAME_ERR.
REQ-032 Short word: a right word truncated to 10 bits -> one oFRAME_ERR pulse, no oVALID that frame, and outputs keep their old values.
REQ-033 Start-up: release reset while LRCK = 0 mid-word -> first oVALID occurs only after the next full left word then right word; oAUD_ADCDAT is 0 until then.
REQ-034 Mid-operation reset: assert iRST for 3 cycles during a left word -> all outputs 0 immediately and HUNT re-entered; next valid pair is reported correctly.
